// File: rtl/tpram_param_if.sv
// Port bundle for tpram_param: write port A, read port B and status.
interface tpram_param_if #(
    parameter int DATA_W = 16,
    parameter int BYTE_W = 8,
    parameter int ADDR_W = 8
);
    localparam int NB = DATA_W / BYTE_W;

    logic              wea;
    logic [NB-1:0]     bea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] data_i_a;
    logic              enb;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] data_o_b;
    logic              valid_o_b;
    logic              init_busy;

    modport master (
        output wea, bea, addra, data_i_a, enb, addrb,
        input  data_o_b, valid_o_b, init_busy
    );

    modport slave (
        input  wea, bea, addra, data_i_a, enb, addrb,
        output data_o_b, valid_o_b, init_busy
    );
endinterface

// File: rtl/tpram_param.sv
// Parametrised two-port RAM: byte-enabled write port, read port with
// same-address forwarding, optional output register and clear-on-reset.
module tpram_param #(
    parameter int DATA_W  = 16,
    parameter int BYTE_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int OUT_REG = 0
) (
    input logic         clk,
    input logic         rst,
    tpram_param_if.slave bus
);
    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_go;
    logic              rd_go;
    logic              hit;
    logic [DATA_W-1:0] rd_word;
    logic              v1;
    logic [DATA_W-1:0] d1;

    assign wr_go = (state == RUN) && bus.wea;
    assign rd_go = (state == RUN) && bus.enb;
    assign hit   = wr_go && (bus.addra == bus.addrb);
    assign bus.init_busy = (state == INIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            clr_addr <= '0;
        end else begin
            state <= state_nx;
            if (state == INIT)
                clr_addr <= clr_addr + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            INIT: if (&clr_addr) state_nx = RUN;
            RUN:  state_nx = RUN;
            default: state_nx = INIT;
        endcase
    end

    // Clearing owns the array while INIT; user writes only in RUN.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[clr_addr] <= '0;
        end else if (wr_go) begin
            for (int i = 0; i < NB; i++)
                if (bus.bea[i])
                    mem[bus.addra][i*BYTE_W +: BYTE_W] <=
                        bus.data_i_a[i*BYTE_W +: BYTE_W];
        end
    end

    // Same-edge write to the read address returns the merged new word.
    always_comb begin
        rd_word = mem[bus.addrb];
        for (int i = 0; i < NB; i++)
            if (hit && bus.bea[i])
                rd_word[i*BYTE_W +: BYTE_W] =
                    bus.data_i_a[i*BYTE_W +: BYTE_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= rd_go;
            if (rd_go)
                d1 <= rd_word;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic              v2;
            logic [DATA_W-1:0] d2;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v2 <= 1'b0;
                    d2 <= '0;
                end else begin
                    v2 <= v1;
                    if (v1)
                        d2 <= d1;
                end
            end

            assign bus.valid_o_b = v2;
            assign bus.data_o_b  = d2;
        end else begin : g_noreg
            assign bus.valid_o_b = v1;
            assign bus.data_o_b  = d1;
        end
    endgenerate
endmodule

// File: tb/tb_tpram_param.sv
// Directed bench for tpram_param: runs OUT_REG=0 (u0) and OUT_REG=1 (u1)
// side by side on identical stimulus.
module tb_tpram_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    tpram_param_if #(.DATA_W(16), .BYTE_W(8), .ADDR_W(4)) bus0 ();
    tpram_param_if #(.DATA_W(16), .BYTE_W(8), .ADDR_W(4)) bus1 ();

    tpram_param #(.DATA_W(16), .BYTE_W(8), .ADDR_W(4), .OUT_REG(0)) u0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    tpram_param #(.DATA_W(16), .BYTE_W(8), .ADDR_W(4), .OUT_REG(1)) u1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    task automatic drive(input logic w, input logic [3:0] wa,
                         input logic [15:0] wd, input logic [1:0] wb,
                         input logic e, input logic [3:0] ra);
        bus0.wea = w; bus0.addra = wa; bus0.data_i_a = wd; bus0.bea = wb;
        bus0.enb = e; bus0.addrb = ra;
        bus1.wea = w; bus1.addra = wa; bus1.data_i_a = wd; bus1.bea = wb;
        bus1.enb = e; bus1.addrb = ra;
    endtask

    task automatic do_write(input logic [3:0] wa, input logic [15:0] wd,
                            input logic [1:0] wb);
        drive(1'b1, wa, wd, wb, 1'b0, 4'd0);
        @(negedge clk);
        drive(1'b0, 4'd0, 16'd0, 2'b00, 1'b0, 4'd0);
    endtask

    // One read (optionally with a same-edge write), checked at both latencies.
    task automatic rw(input logic w, input logic [3:0] wa,
                      input logic [15:0] wd, input logic [1:0] wb,
                      input logic [3:0] ra, input logic [15:0] exp,
                      input string nm);
        drive(w, wa, wd, wb, 1'b1, ra);
        @(negedge clk);
        drive(1'b0, 4'd0, 16'd0, 2'b00, 1'b0, 4'd0);
        n_chk++;
        if (bus0.valid_o_b !== 1'b1 || bus0.data_o_b !== exp) begin
            n_fail++;
            $display("FAIL %s u0 lat1: valid=%b data=%h want valid=1 data=%h",
                     nm, bus0.valid_o_b, bus0.data_o_b, exp);
        end
        n_chk++;
        if (bus1.valid_o_b !== 1'b0) begin
            n_fail++;
            $display("FAIL %s u1 early: valid=%b want 0", nm, bus1.valid_o_b);
        end
        @(negedge clk);
        n_chk++;
        if (bus0.valid_o_b !== 1'b0 || bus0.data_o_b !== exp) begin
            n_fail++;
            $display("FAIL %s u0 hold: valid=%b data=%h want valid=0 data=%h",
                     nm, bus0.valid_o_b, bus0.data_o_b, exp);
        end
        n_chk++;
        if (bus1.valid_o_b !== 1'b1 || bus1.data_o_b !== exp) begin
            n_fail++;
            $display("FAIL %s u1 lat2: valid=%b data=%h want valid=1 data=%h",
                     nm, bus1.valid_o_b, bus1.data_o_b, exp);
        end
        @(negedge clk);
        n_chk++;
        if (bus1.valid_o_b !== 1'b0 || bus1.data_o_b !== exp) begin
            n_fail++;
            $display("FAIL %s u1 hold: valid=%b data=%h want valid=0 data=%h",
                     nm, bus1.valid_o_b, bus1.data_o_b, exp);
        end
    endtask

    // Counts the 16 clear edges after rst release; optional dropped request.
    task automatic init_walk(input string nm, input bit pulse);
        for (int k = 1; k <= 16; k++) begin
            if (pulse && k == 5)
                drive(1'b1, 4'd2, 16'hFFFF, 2'b11, 1'b1, 4'd2);
            @(negedge clk);
            drive(1'b0, 4'd0, 16'd0, 2'b00, 1'b0, 4'd0);
            n_chk++;
            if (bus0.init_busy !== (k < 16) || bus1.init_busy !== (k < 16)) begin
                n_fail++;
                $display("FAIL %s busy edge %0d: u0=%b u1=%b want %b",
                         nm, k, bus0.init_busy, bus1.init_busy, k < 16);
            end
            n_chk++;
            if (bus0.valid_o_b !== 1'b0 || bus1.valid_o_b !== 1'b0) begin
                n_fail++;
                $display("FAIL %s valid during init edge %0d: u0=%b u1=%b want 0",
                         nm, k, bus0.valid_o_b, bus1.valid_o_b);
            end
        end
    endtask

    task automatic test_reset;
        drive(1'b0, 4'd0, 16'd0, 2'b00, 1'b0, 4'd0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (bus0.init_busy !== 1'b1 || bus0.valid_o_b !== 1'b0 ||
            bus0.data_o_b !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset u0: busy=%b valid=%b data=%h want 1 0 0000",
                     bus0.init_busy, bus0.valid_o_b, bus0.data_o_b);
        end
        n_chk++;
        if (bus1.init_busy !== 1'b1 || bus1.valid_o_b !== 1'b0 ||
            bus1.data_o_b !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset u1: busy=%b valid=%b data=%h want 1 0 0000",
                     bus1.init_busy, bus1.valid_o_b, bus1.data_o_b);
        end
    endtask

    task automatic test_init;
        rst = 1'b0;
        init_walk("init", 1'b1);
        for (int t = 0; t < 18; t++) begin
            if (t < 16)
                drive(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'(t));
            else
                drive(1'b0, 4'd0, 16'd0, 2'b00, 1'b0, 4'd0);
            @(negedge clk);
            n_chk++;
            if (bus0.valid_o_b !== (t < 16) || bus0.data_o_b !== 16'h0000) begin
                n_fail++;
                $display("FAIL sweep u0 t=%0d: valid=%b data=%h want valid=%b data=0000",
                         t, bus0.valid_o_b, bus0.data_o_b, t < 16);
            end
            n_chk++;
            if (bus1.valid_o_b !== (t >= 1 && t <= 16) ||
                bus1.data_o_b !== 16'h0000) begin
                n_fail++;
                $display("FAIL sweep u1 t=%0d: valid=%b data=%h want valid=%b data=0000",
                         t, bus1.valid_o_b, bus1.data_o_b, t >= 1 && t <= 16);
            end
        end
    endtask

    task automatic test_busy_drop;
        rw(1'b0, 4'd0, 16'd0, 2'b00, 4'd2, 16'h0000, "busy_drop");
    endtask

    task automatic test_write_read;
        do_write(4'd3, 16'hBEEF, 2'b11);
        rw(1'b0, 4'd0, 16'd0, 2'b00, 4'd3, 16'hBEEF, "wr_rd");
    endtask

    task automatic test_byte_lanes;
        do_write(4'd3, 16'h1234, 2'b01);
        rw(1'b0, 4'd0, 16'd0, 2'b00, 4'd3, 16'hBE34, "lane_lo");
        do_write(4'd3, 16'h5678, 2'b00);
        rw(1'b0, 4'd0, 16'd0, 2'b00, 4'd3, 16'hBE34, "lane_none");
        do_write(4'd3, 16'h9A00, 2'b10);
        rw(1'b0, 4'd0, 16'd0, 2'b00, 4'd3, 16'h9A34, "lane_hi");
    endtask

    task automatic test_forwarding;
        rw(1'b1, 4'd5, 16'hA5A5, 2'b10, 4'd5, 16'hA500, "fwd_same");
        rw(1'b1, 4'd6, 16'h1111, 2'b11, 4'd5, 16'hA500, "fwd_other");
        rw(1'b0, 4'd0, 16'd0, 2'b00, 4'd6, 16'h1111, "fwd_other_wr");
    endtask

    task automatic test_back_to_back;
        do_write(4'd8, 16'hC0DE, 2'b11);
        drive(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'd3);
        @(negedge clk);
        drive(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'd8);
        n_chk++;
        if (bus0.valid_o_b !== 1'b1 || bus0.data_o_b !== 16'h9A34) begin
            n_fail++;
            $display("FAIL b2b u0 first: valid=%b data=%h want 1 9a34",
                     bus0.valid_o_b, bus0.data_o_b);
        end
        @(negedge clk);
        drive(1'b0, 4'd0, 16'd0, 2'b00, 1'b0, 4'd0);
        n_chk++;
        if (bus0.valid_o_b !== 1'b1 || bus0.data_o_b !== 16'hC0DE ||
            bus1.valid_o_b !== 1'b1 || bus1.data_o_b !== 16'h9A34) begin
            n_fail++;
            $display("FAIL b2b mid: u0 %b/%h u1 %b/%h want 1/c0de 1/9a34",
                     bus0.valid_o_b, bus0.data_o_b, bus1.valid_o_b, bus1.data_o_b);
        end
        @(negedge clk);
        n_chk++;
        if (bus0.valid_o_b !== 1'b0 || bus1.valid_o_b !== 1'b1 ||
            bus1.data_o_b !== 16'hC0DE) begin
            n_fail++;
            $display("FAIL b2b tail: u0 valid=%b u1 %b/%h want 0 and 1/c0de",
                     bus0.valid_o_b, bus1.valid_o_b, bus1.data_o_b);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        do_write(4'd7, 16'h5555, 2'b11);
        rw(1'b0, 4'd0, 16'd0, 2'b00, 4'd7, 16'h5555, "pre_rst");
        drive(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'd7);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b0, 4'd0, 16'd0, 2'b00, 1'b0, 4'd0);
        #1;
        n_chk++;
        if (bus0.data_o_b !== 16'h0000 || bus0.valid_o_b !== 1'b0 ||
            bus1.data_o_b !== 16'h0000 || bus1.valid_o_b !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: u0 %b/%h u1 %b/%h want 0/0000",
                     bus0.valid_o_b, bus0.data_o_b, bus1.valid_o_b, bus1.data_o_b);
        end
        n_chk++;
        if (bus0.init_busy !== 1'b1 || bus1.init_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_busy: u0=%b u1=%b want 1",
                     bus0.init_busy, bus1.init_busy);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_chk++;
            if (bus0.valid_o_b !== 1'b0 || bus1.valid_o_b !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_strobe %0d: u0=%b u1=%b want 0",
                         k, bus0.valid_o_b, bus1.valid_o_b);
            end
        end
        rst = 1'b0;
        init_walk("reinit", 1'b0);
        rw(1'b0, 4'd0, 16'd0, 2'b00, 4'd7, 16'h0000, "reinit_rd7");
        rw(1'b0, 4'd0, 16'd0, 2'b00, 4'd3, 16'h0000, "reinit_rd3");
    endtask

    initial begin
        test_reset();
        test_init();
        test_busy_drop();
        test_write_read();
        test_byte_lanes();
        test_forwarding();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
